// File: rtl/serial_2_parallel.sv
// Receive-side deserializer: rebuilds LANES signed complex bins from 2*LANES
// MSB-first serial lanes and presents them as registered words with a valid pulse.
module serial_2_parallel #(
    parameter int LANES = 32,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [0:LANES-1]        real_in,
    input  logic [0:LANES-1]        imag_in,
    output logic signed [WIDTH-1:0] real_out [0:LANES-1],
    output logic signed [WIDTH-1:0] imag_out [0:LANES-1],
    output logic                    out_valid,
    output logic                    frame_abort,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          sample;
    logic          load;
    logic          abort;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sample     = 1'b0;
        load       = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    sample     = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    sample = 1'b1;
                    if (cnt_reg == LAST) begin
                        load       = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    abort      = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            out_valid   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            out_valid   <= load;
            frame_abort <= abort;
        end
    end

    assign busy = (state_reg == SHIFT);

    // Only the low WIDTH-1 history bits are ever observed (the oldest bit falls
    // off on the final shift), so each lane keeps WIDTH-1 bits of history and
    // the completed word is history plus the bit currently on the lane.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-2:0] hist_r_reg, hist_i_reg;
            logic [WIDTH-1:0] word_r_next, word_i_next;

            assign word_r_next = {hist_r_reg, real_in[gi]};
            assign word_i_next = {hist_i_reg, imag_in[gi]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_r_reg   <= '0;
                    hist_i_reg   <= '0;
                    real_out[gi] <= '0;
                    imag_out[gi] <= '0;
                end else begin
                    if (sample) begin
                        hist_r_reg <= word_r_next[WIDTH-2:0];
                        hist_i_reg <= word_i_next[WIDTH-2:0];
                    end
                    if (load) begin
                        real_out[gi] <= word_r_next;
                        imag_out[gi] <= word_i_next;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/serial_2_parallel.md
Name: serial_2_parallel

Overview:
- Receive-side deserializer directly downstream of the FFT parallel-to-serial stage.
- Collects 32 real and 32 imaginary single-bit lanes, MSB first, WIDTH bits per frame.
- Rebuilds 32 signed complex FFT bins and presents them as registered parallel words with a one-cycle valid strobe.
- Sits between the serial link and the bin-consumer logic (magnitude/compare/capture).

Parameters:
- LANES, 32, number of complex bins; each bin has one real lane and one imag lane.
- WIDTH, 16, bits per sample; two's complement.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  frame-active qualifier; a bit is sampled on every lane only in cycles where enable=1.
- real_in  input  1 x [0:LANES-1]  serial real bit per bin, MSB first.
- imag_in  input  1 x [0:LANES-1]  serial imag bit per bin, MSB first.
- real_out  output  signed WIDTH x [0:LANES-1]  reassembled real parts; holds until the next completed frame.
- imag_out  output  signed WIDTH x [0:LANES-1]  reassembled imag parts; same hold rule.
- out_valid  output  1  one-cycle pulse: real_out/imag_out updated this cycle.
- frame_abort  output  1  one-cycle pulse: a partial frame was discarded.
- busy  output  1  high while a frame is partially received (state SHIFT).

Behaviour:
- Reset: state=IDLE, bit counter=0, shift registers=0, real_out/imag_out all 0, out_valid=0, frame_abort=0, busy=0.
- Reset mid-frame: clears all state immediately. The partial frame is lost and no abort pulse is raised.
- Each lane has a WIDTH-bit shift register. On a sampled bit: sr <= {sr[WIDTH-2:0], bit_in}. All 2*LANES lanes shift in lockstep on one shared counter.
- FSM, state IDLE:
  - enable=1: sample bit 0, counter=1, go to SHIFT.
  - enable=0: stay in IDLE.
- FSM, state SHIFT, enable=1 and counter<WIDTH-1: sample the bit, counter++.
- FSM, state SHIFT, enable=1 and counter==WIDTH-1 (last bit):
  - On the same edge, load real_out[i]={sr_r[i][WIDTH-2:0], real_in[i]} and likewise imag_out[i].
  - Set out_valid=1, counter=0, go to IDLE.
  - Latency: outputs and out_valid are visible in the cycle after the last bit is present on the inputs.
- FSM, state SHIFT, enable=0: discard the partial frame, counter=0, frame_abort=1 for one cycle, go to IDLE. real_out/imag_out are unchanged.
- Back-to-back frames: if enable stays high across the boundary, the cycle after the last bit is bit 0 of the next frame. IDLE accepts it immediately, so there is no gap and no lost bit. out_valid pulses every WIDTH cycles.
- out_valid and frame_abort are registered. They are never high together and deassert the following cycle unless re-triggered.
- busy = (state==SHIFT).
- Output words are raw bit patterns, interpreted as signed; no rounding or saturation.
- WIDTH=1 is not supported. The counter width is clog2(WIDTH).

Test Plan:
- Basic frame: drive enable=1 for 16 cycles.
  - Real lane 0 carries 0x8001, MSB first; imag lane 31 carries 0x7FFF; all other lanes 0.
  - Required: cycle 17 has out_valid=1, real_out[0]=-32767, imag_out[31]=32767, all other outputs 0, busy=0.
- All-lanes pattern: lane i real=i*0x0101, imag=~(i*0x0101).
  - Required: every bin matches after a single out_valid pulse.
- Back-to-back: enable high for 48 cycles with three distinct frames (0x1234, 0xFFFF, 0x0000 on real lane 5).
  - Required: out_valid at cycles 17, 33 and 49, and real_out[5] = 4660, then -1, then 0.
- Abort: enable high for 9 cycles, then low.
  - Required: frame_abort=1 for exactly one cycle, out_valid stays 0, outputs keep their previous frame's values.
  - A subsequent full frame decodes correctly.
- Gapped enable: a 16-bit frame with enable=0 inserted after bit 15 only, i.e. the last bit is delayed by one cycle.
  - Required: abort fires and no out_valid.
  - Separately, a frame with enable continuously high decodes correctly, confirming there is no hold-over state.
- Async reset mid-frame: assert rst_n=0 after 7 bits, asynchronously and off the clock edge.
  - Required: all outputs 0 immediately, no abort pulse.
  - After release, a clean 16-bit frame yields correct values.
